// File: rtl/decode_pipe_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : decode_pipe_stage_pkg
// Description : Shared instruction/control types, encodings and immediate
//               extension for the decode stage.
// Revision    : 1.0 - initial release
// ============================================================================
package decode_pipe_stage_pkg;

  localparam logic [6:0] c_opc_load   = 7'b0000011;
  localparam logic [6:0] c_opc_op_imm = 7'b0010011;
  localparam logic [6:0] c_opc_auipc  = 7'b0010111;
  localparam logic [6:0] c_opc_store  = 7'b0100011;
  localparam logic [6:0] c_opc_op     = 7'b0110011;
  localparam logic [6:0] c_opc_lui    = 7'b0110111;
  localparam logic [6:0] c_opc_branch = 7'b1100011;
  localparam logic [6:0] c_opc_jalr   = 7'b1100111;
  localparam logic [6:0] c_opc_jal    = 7'b1101111;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } instruction_type;

  typedef enum logic [2:0] {
    ENC_R = 3'd0,
    ENC_I = 3'd1,
    ENC_S = 3'd2,
    ENC_B = 3'd3,
    ENC_U = 3'd4,
    ENC_J = 3'd5
  } encoding_type;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       branch;
    logic       jump;
    logic       alu_src;
    logic [3:0] alu_op;
  } control_type;

  function automatic logic uses_rs2(encoding_type enc);
    return (enc == ENC_R) || (enc == ENC_S) || (enc == ENC_B);
  endfunction

  // Returns a 32-bit sign-extended immediate; callers widen to XLEN.
  function automatic logic [31:0] immediate_extension(instruction_type instr, encoding_type enc);
    logic [31:0] imm;
    imm = '0;
    case (enc)
      ENC_I:   imm = {{20{instr[31]}}, instr[31:20]};
      ENC_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      ENC_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      ENC_U:   imm = {instr[31:12], 12'b0};
      ENC_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage
`default_nettype wire

// File: rtl/decode_pipe_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : decode_pipe_stage_if
// Description : Fetch, writeback and ID/EX signals of the decode stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface decode_pipe_stage_if #(
  parameter int XLEN     = 32,
  parameter int REG_ID_W = 5
);
  import decode_pipe_stage_pkg::*;

  logic                in_valid;
  logic                in_ready;
  instruction_type     instruction;
  logic [XLEN-1:0]     pc_in;
  logic                flush;
  logic                write_en;
  logic [REG_ID_W-1:0] write_id;
  logic [XLEN-1:0]     write_data;
  logic                out_valid;
  logic                out_ready;
  logic [REG_ID_W-1:0] reg_rd_id;
  logic [REG_ID_W-1:0] rs1_id;
  logic [REG_ID_W-1:0] rs2_id;
  logic [XLEN-1:0]     read_data1;
  logic [XLEN-1:0]     read_data2;
  logic [XLEN-1:0]     immediate_data;
  logic [XLEN-1:0]     pc_out;
  control_type         control_signals;
  logic                hazard_stall;

  modport master (
    output in_valid, instruction, pc_in, flush, write_en, write_id, write_data, out_ready,
    input  in_ready, out_valid, reg_rd_id, rs1_id, rs2_id, read_data1, read_data2,
           immediate_data, pc_out, control_signals, hazard_stall
  );

  modport slave (
    input  in_valid, instruction, pc_in, flush, write_en, write_id, write_data, out_ready,
    output in_ready, out_valid, reg_rd_id, rs1_id, rs2_id, read_data1, read_data2,
           immediate_data, pc_out, control_signals, hazard_stall
  );

endinterface
`default_nettype wire

// File: rtl/decode_pipe_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : control_decoder
// Description : Opcode to control-word and encoding-format decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module control_decoder
  import decode_pipe_stage_pkg::*;
(
  input  instruction_type i_instr,
  output control_type     o_ctrl,
  output encoding_type    o_enc
);

  always_comb begin
    o_ctrl = '0;
    o_enc  = ENC_R;
    case (i_instr.opcode)
      c_opc_op: begin
        o_enc            = ENC_R;
        o_ctrl.reg_write = 1'b1;
        o_ctrl.alu_op    = {i_instr.funct7[5], i_instr.funct3};
      end
      c_opc_op_imm: begin
        o_enc            = ENC_I;
        o_ctrl.reg_write = 1'b1;
        o_ctrl.alu_src   = 1'b1;
        // Only shift-right-immediate carries the arithmetic flag in funct7.
        o_ctrl.alu_op    = {(i_instr.funct3 == 3'b101) & i_instr.funct7[5], i_instr.funct3};
      end
      c_opc_load: begin
        o_enc             = ENC_I;
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.mem_read   = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
        o_ctrl.alu_src    = 1'b1;
      end
      c_opc_store: begin
        o_enc            = ENC_S;
        o_ctrl.mem_write = 1'b1;
        o_ctrl.alu_src   = 1'b1;
      end
      c_opc_branch: begin
        o_enc         = ENC_B;
        o_ctrl.branch = 1'b1;
        o_ctrl.alu_op = 4'b1000;
      end
      c_opc_lui, c_opc_auipc: begin
        o_enc            = ENC_U;
        o_ctrl.reg_write = 1'b1;
        o_ctrl.alu_src   = 1'b1;
      end
      c_opc_jal: begin
        o_enc            = ENC_J;
        o_ctrl.reg_write = 1'b1;
        o_ctrl.jump      = 1'b1;
      end
      c_opc_jalr: begin
        o_enc            = ENC_I;
        o_ctrl.reg_write = 1'b1;
        o_ctrl.jump      = 1'b1;
        o_ctrl.alu_src   = 1'b1;
      end
      default: begin
        o_ctrl = '0;
        o_enc  = ENC_R;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/decode_pipe_stage_regfile.sv
`default_nettype none
// ============================================================================
// Module      : regfile_bypass
// Description : Two-read, one-write register file with write-through bypass;
//               entry 0 is hardwired to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_bypass #(
  parameter  int XLEN     = 32,
  parameter  int NUM_REGS = 32,
  localparam int ID_W     = $clog2(NUM_REGS)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            i_we,
  input  logic [ID_W-1:0] i_waddr,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [ID_W-1:0] i_raddr1,
  input  logic [ID_W-1:0] i_raddr2,
  output logic [XLEN-1:0] o_rdata1,
  output logic [XLEN-1:0] o_rdata2
);

  logic [XLEN-1:0] r_regs [NUM_REGS];
  logic [ID_W-1:0] w_raddr [2];
  logic [XLEN-1:0] w_rdata [2];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_we && (i_waddr != '0)) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign w_raddr[0] = i_raddr1;
  assign w_raddr[1] = i_raddr2;

  // A nonzero read index equal to the write index implies a nonzero write.
  for (genvar p = 0; p < 2; p++) begin : g_rd_port
    assign w_rdata[p] = (w_raddr[p] == '0)                   ? '0      :
                        (i_we && (i_waddr == w_raddr[p]))    ? i_wdata :
                                                               r_regs[w_raddr[p]];
  end

  assign o_rdata1 = w_rdata[0];
  assign o_rdata2 = w_rdata[1];

endmodule
`default_nettype wire

// File: rtl/decode_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module      : decode_pipe_stage
// Description : Instruction decode with register read, load-use stall, flush
//               and an ID/EX pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_pipe_stage
  import decode_pipe_stage_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int REG_ID_W = $clog2(NUM_REGS)
) (
  input  logic               clk,
  input  logic               reset_n,
  decode_pipe_stage_if.slave bus
);

  instruction_type     w_instr;
  control_type         w_ctrl;
  encoding_type        w_enc;
  logic [REG_ID_W-1:0] w_rs1;
  logic [REG_ID_W-1:0] w_rs2;
  logic [REG_ID_W-1:0] w_rd;
  logic [XLEN-1:0]     w_rdata1;
  logic [XLEN-1:0]     w_rdata2;
  logic [XLEN-1:0]     w_imm;
  logic                w_hazard;
  logic                w_load;
  logic                w_issue;

  logic                r_valid;
  control_type         r_ctrl;
  logic [REG_ID_W-1:0] r_rd;
  logic [REG_ID_W-1:0] r_rs1;
  logic [REG_ID_W-1:0] r_rs2;
  logic [XLEN-1:0]     r_rdata1;
  logic [XLEN-1:0]     r_rdata2;
  logic [XLEN-1:0]     r_imm;
  logic [XLEN-1:0]     r_pc;

  assign w_instr = bus.instruction;
  assign w_rs1   = REG_ID_W'(w_instr.rs1);
  assign w_rs2   = REG_ID_W'(w_instr.rs2);
  assign w_rd    = REG_ID_W'(w_instr.rd);
  assign w_imm   = XLEN'($signed(immediate_extension(w_instr, w_enc)));

  control_decoder u_ctrl (
    .i_instr (w_instr),
    .o_ctrl  (w_ctrl),
    .o_enc   (w_enc)
  );

  regfile_bypass #(
    .XLEN     (XLEN),
    .NUM_REGS (NUM_REGS)
  ) u_regfile (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_we     (bus.write_en),
    .i_waddr  (bus.write_id),
    .i_wdata  (bus.write_data),
    .i_raddr1 (w_rs1),
    .i_raddr2 (w_rs2),
    .o_rdata1 (w_rdata1),
    .o_rdata2 (w_rdata2)
  );

  // A load in ID/EX whose destination feeds the incoming instruction must bubble.
  assign w_hazard = bus.in_valid && r_valid && r_ctrl.mem_read && (r_rd != '0) &&
                    ((r_rd == w_rs1) || (uses_rs2(w_enc) && (r_rd == w_rs2)));
  assign w_load   = !r_valid || bus.out_ready;
  assign w_issue  = bus.in_valid && !w_hazard;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid  <= 1'b0;
      r_ctrl   <= '0;
      r_rd     <= '0;
      r_rs1    <= '0;
      r_rs2    <= '0;
      r_rdata1 <= '0;
      r_rdata2 <= '0;
      r_imm    <= '0;
      r_pc     <= '0;
    end else if (bus.flush) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
    end else if (w_load) begin
      r_valid  <= w_issue;
      r_ctrl   <= w_issue ? w_ctrl : '0;
      r_rd     <= w_rd;
      r_rs1    <= w_rs1;
      r_rs2    <= w_rs2;
      r_rdata1 <= w_rdata1;
      r_rdata2 <= w_rdata2;
      r_imm    <= w_imm;
      r_pc     <= bus.pc_in;
    end
  end

  assign bus.in_ready        = w_load && !w_hazard && !bus.flush;
  assign bus.hazard_stall    = w_hazard;
  assign bus.out_valid       = r_valid;
  assign bus.control_signals = r_ctrl;
  assign bus.reg_rd_id       = r_rd;
  assign bus.rs1_id          = r_rs1;
  assign bus.rs2_id          = r_rs2;
  assign bus.read_data1      = r_rdata1;
  assign bus.read_data2      = r_rdata2;
  assign bus.immediate_data  = r_imm;
  assign bus.pc_out          = r_pc;

endmodule
`default_nettype wire

// File: tb/tb_decode_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_pipe_stage
// Description : Directed self-checking bench for decode_pipe_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_pipe_stage;
  import decode_pipe_stage_pkg::*;

  localparam int XLEN     = 32;
  localparam int NUM_REGS = 32;
  localparam int REG_ID_W = 5;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;

  logic clk = 1'b0;
  logic reset_n;
  int   checks   = 0;
  int   failures = 0;

  decode_pipe_stage_if #(.XLEN(XLEN), .REG_ID_W(REG_ID_W)) bus ();

  decode_pipe_stage #(
    .XLEN     (XLEN),
    .NUM_REGS (NUM_REGS),
    .REG_ID_W (REG_ID_W)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                        logic [4:0] rd, logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_add(logic [4:0] rs2, logic [4:0] rs1, logic [4:0] rd);
    return {7'd0, rs2, rs1, 3'd0, rd, 7'b0110011};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
    bus.in_valid    = v;
    bus.instruction = instruction_type'(ins);
    bus.pc_in       = pc;
  endtask

  task automatic test_reset;
    reset_n        = 1'b0;
    bus.flush      = 1'b0;
    bus.write_en   = 1'b0;
    bus.write_id   = '0;
    bus.write_data = '0;
    bus.out_ready  = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    #2;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", bus.in_ready); end
    checks++; if (bus.pc_out !== 32'h0 || bus.immediate_data !== 32'h0 || bus.control_signals !== control_type'(0))
      begin failures++; $display("FAIL reset_outputs pc=%0h imm=%0h ctrl=%0h exp=0", bus.pc_out, bus.immediate_data, bus.control_signals); end
    tick;
    tick;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_held_valid got=%0b exp=0", bus.out_valid); end
    reset_n = 1'b1;
  endtask

  task automatic test_addi;
    drive(1'b1, enc_i(12'd5, 5'd0, 3'd0, 5'd1, OP_IMM), 32'h100);
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL addi_in_ready got=%0b exp=1", bus.in_ready); end
    tick;
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL addi_valid got=%0b exp=1", bus.out_valid); end
    checks++; if (bus.immediate_data !== 32'd5) begin failures++; $display("FAIL addi_imm got=%0h exp=5", bus.immediate_data); end
    checks++; if (bus.reg_rd_id !== 5'd1) begin failures++; $display("FAIL addi_rd got=%0d exp=1", bus.reg_rd_id); end
    checks++; if (bus.pc_out !== 32'h100) begin failures++; $display("FAIL addi_pc got=%0h exp=100", bus.pc_out); end
    checks++; if (bus.control_signals.reg_write !== 1'b1 || bus.control_signals.alu_src !== 1'b1 || bus.control_signals.mem_read !== 1'b0)
      begin failures++; $display("FAIL addi_ctrl got=%0h exp=reg_write,alu_src", bus.control_signals); end
    drive(1'b0, 32'h0, 32'h0);
    tick;
    checks++; if (bus.out_valid !== 1'b0 || bus.control_signals !== control_type'(0))
      begin failures++; $display("FAIL idle_no_dup valid=%0b ctrl=%0h exp=0", bus.out_valid, bus.control_signals); end
  endtask

  task automatic test_bypass;
    bus.write_en = 1'b1; bus.write_id = 5'd3; bus.write_data = 32'hDEADBEEF;
    drive(1'b1, enc_add(5'd0, 5'd3, 5'd4), 32'h104);
    tick;
    checks++; if (bus.read_data1 !== 32'hDEADBEEF) begin failures++; $display("FAIL bypass_rd1 got=%0h exp=deadbeef", bus.read_data1); end
    checks++; if (bus.rs1_id !== 5'd3 || bus.reg_rd_id !== 5'd4) begin failures++; $display("FAIL bypass_ids rs1=%0d rd=%0d exp=3,4", bus.rs1_id, bus.reg_rd_id); end
    bus.write_id = 5'd1; bus.write_data = 32'h55;
    drive(1'b1, enc_add(5'd3, 5'd3, 5'd7), 32'h108);
    tick;
    checks++; if (bus.read_data1 !== 32'hDEADBEEF || bus.read_data2 !== 32'hDEADBEEF)
      begin failures++; $display("FAIL stored_x3 rd1=%0h rd2=%0h exp=deadbeef", bus.read_data1, bus.read_data2); end
    bus.write_en = 1'b0;
    drive(1'b1, enc_add(5'd1, 5'd0, 5'd2), 32'h10C);
    tick;
    checks++; if (bus.read_data2 !== 32'h55 || bus.read_data1 !== 32'h0)
      begin failures++; $display("FAIL stored_x1 rd1=%0h rd2=%0h exp=0,55", bus.read_data1, bus.read_data2); end
    drive(1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_load_use;
    drive(1'b1, enc_i(12'd0, 5'd2, 3'b010, 5'd5, OP_LD), 32'h200);
    tick;
    checks++; if (bus.out_valid !== 1'b1 || bus.control_signals.mem_read !== 1'b1 || bus.reg_rd_id !== 5'd5)
      begin failures++; $display("FAIL lw_issue valid=%0b ctrl=%0h rd=%0d exp=1,mem_read,5", bus.out_valid, bus.control_signals, bus.reg_rd_id); end
    drive(1'b1, enc_add(5'd1, 5'd5, 5'd6), 32'h204);
    #1;
    checks++; if (bus.hazard_stall !== 1'b1 || bus.in_ready !== 1'b0)
      begin failures++; $display("FAIL lu_stall stall=%0b ready=%0b exp=1,0", bus.hazard_stall, bus.in_ready); end
    tick;
    checks++; if (bus.out_valid !== 1'b0 || bus.control_signals !== control_type'(0))
      begin failures++; $display("FAIL lu_bubble valid=%0b ctrl=%0h exp=0", bus.out_valid, bus.control_signals); end
    checks++; if (bus.hazard_stall !== 1'b0 || bus.in_ready !== 1'b1)
      begin failures++; $display("FAIL lu_release stall=%0b ready=%0b exp=0,1", bus.hazard_stall, bus.in_ready); end
    tick;
    checks++; if (bus.out_valid !== 1'b1 || bus.pc_out !== 32'h204 || bus.reg_rd_id !== 5'd6 || bus.rs2_id !== 5'd1 || bus.read_data2 !== 32'h55)
      begin failures++; $display("FAIL lu_add valid=%0b pc=%0h rd=%0d rs2=%0d rd2=%0h exp=1,204,6,1,55", bus.out_valid, bus.pc_out, bus.reg_rd_id, bus.rs2_id, bus.read_data2); end
    drive(1'b1, enc_i(12'd0, 5'd2, 3'b010, 5'd5, OP_LD), 32'h208);
    tick;
    drive(1'b1, enc_add(5'd5, 5'd1, 5'd6), 32'h20C);
    #1;
    checks++; if (bus.hazard_stall !== 1'b1) begin failures++; $display("FAIL lu_rs2_stall got=%0b exp=1", bus.hazard_stall); end
    tick;
    tick;
    drive(1'b1, enc_i(12'd0, 5'd2, 3'b010, 5'd5, OP_LD), 32'h210);
    tick;
    // I-type whose immediate bits alias rs2=5 must not stall.
    drive(1'b1, enc_i(12'd5, 5'd1, 3'd0, 5'd8, OP_IMM), 32'h214);
    #1;
    checks++; if (bus.hazard_stall !== 1'b0 || bus.in_ready !== 1'b1)
      begin failures++; $display("FAIL itype_no_stall stall=%0b ready=%0b exp=0,1", bus.hazard_stall, bus.in_ready); end
    tick;
    checks++; if (bus.out_valid !== 1'b1 || bus.pc_out !== 32'h214) begin failures++; $display("FAIL itype_issue valid=%0b pc=%0h exp=1,214", bus.out_valid, bus.pc_out); end
    drive(1'b1, enc_i(12'd0, 5'd2, 3'b010, 5'd0, OP_LD), 32'h218);
    tick;
    drive(1'b1, enc_add(5'd0, 5'd0, 5'd6), 32'h21C);
    #1;
    checks++; if (bus.hazard_stall !== 1'b0) begin failures++; $display("FAIL lw_x0_no_stall got=%0b exp=0", bus.hazard_stall); end
    drive(1'b0, 32'h0, 32'h0);
    tick;
  endtask

  task automatic test_backpressure;
    drive(1'b1, enc_i(12'h07F, 5'd0, 3'd0, 5'd9, OP_IMM), 32'h300);
    tick;
    bus.out_ready = 1'b0;
    drive(1'b1, enc_i(12'd1, 5'd0, 3'd0, 5'd10, OP_IMM), 32'h304);
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready cyc=%0d got=%0b exp=0", c, bus.in_ready); end
      tick;
      checks++; if (bus.out_valid !== 1'b1 || bus.pc_out !== 32'h300 || bus.reg_rd_id !== 5'd9 || bus.immediate_data !== 32'h7F)
        begin failures++; $display("FAIL bp_hold cyc=%0d valid=%0b pc=%0h rd=%0d imm=%0h exp=1,300,9,7f", c, bus.out_valid, bus.pc_out, bus.reg_rd_id, bus.immediate_data); end
    end
    bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%0b exp=1", bus.in_ready); end
    tick;
    checks++; if (bus.pc_out !== 32'h304 || bus.reg_rd_id !== 5'd10) begin failures++; $display("FAIL bp_next pc=%0h rd=%0d exp=304,10", bus.pc_out, bus.reg_rd_id); end
    drive(1'b0, 32'h0, 32'h0);
    tick;
  endtask

  task automatic test_flush;
    drive(1'b1, enc_i(12'd0, 5'd2, 3'b010, 5'd5, OP_LD), 32'h400);
    tick;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b1;
    drive(1'b1, enc_add(5'd1, 5'd5, 5'd6), 32'h404);
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL flush_in_ready got=%0b exp=0", bus.in_ready); end
    tick;
    checks++; if (bus.out_valid !== 1'b0 || bus.control_signals !== control_type'(0) || bus.pc_out === 32'h404)
      begin failures++; $display("FAIL flush_clear valid=%0b ctrl=%0h pc=%0h exp=0,0,not404", bus.out_valid, bus.control_signals, bus.pc_out); end
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    bus.write_en = 1'b1; bus.write_id = 5'd0; bus.write_data = 32'h1234;
    drive(1'b1, enc_add(5'd0, 5'd0, 5'd11), 32'h408);
    tick;
    checks++; if (bus.out_valid !== 1'b1 || bus.read_data1 !== 32'h0 || bus.read_data2 !== 32'h0)
      begin failures++; $display("FAIL x0_bypass valid=%0b rd1=%0h rd2=%0h exp=1,0,0", bus.out_valid, bus.read_data1, bus.read_data2); end
    bus.write_en = 1'b0;
    drive(1'b1, enc_add(5'd0, 5'd0, 5'd12), 32'h40C);
    tick;
    checks++; if (bus.read_data1 !== 32'h0) begin failures++; $display("FAIL x0_read got=%0h exp=0", bus.read_data1); end
    drive(1'b0, 32'h0, 32'h0);
    tick;
  endtask

  task automatic test_reset_midstall;
    drive(1'b1, enc_i(12'd0, 5'd2, 3'b010, 5'd5, OP_LD), 32'h500);
    tick;
    drive(1'b1, enc_add(5'd1, 5'd5, 5'd6), 32'h504);
    #1;
    checks++; if (bus.hazard_stall !== 1'b1) begin failures++; $display("FAIL mid_stall_setup got=%0b exp=1", bus.hazard_stall); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.hazard_stall !== 1'b0)
      begin failures++; $display("FAIL mid_reset_valid valid=%0b stall=%0b exp=0,0", bus.out_valid, bus.hazard_stall); end
    checks++; if (bus.pc_out !== 32'h0 || bus.reg_rd_id !== 5'd0 || bus.read_data1 !== 32'h0 || bus.control_signals !== control_type'(0))
      begin failures++; $display("FAIL mid_reset_outputs pc=%0h rd=%0d rd1=%0h ctrl=%0h exp=0", bus.pc_out, bus.reg_rd_id, bus.read_data1, bus.control_signals); end
    drive(1'b0, 32'h0, 32'h0);
    #2;
    reset_n = 1'b1;
    tick;
    drive(1'b1, enc_add(5'd1, 5'd3, 5'd4), 32'h600);
    tick;
    checks++; if (bus.out_valid !== 1'b1 || bus.pc_out !== 32'h600 || bus.read_data1 !== 32'h0 || bus.read_data2 !== 32'h0)
      begin failures++; $display("FAIL post_reset valid=%0b pc=%0h rd1=%0h rd2=%0h exp=1,600,0,0", bus.out_valid, bus.pc_out, bus.read_data1, bus.read_data2); end
    drive(1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    test_reset();
    test_addi();
    test_bypass();
    test_load_use();
    test_backpressure();
    test_flush();
    test_reset_midstall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/decode_pipe_stage.md
DECODE_PIPE_STAGE -- requirements
Module: decode_pipe_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath and register width.
REQ-002 SHALL have parameter NUM_REGS, default 32, meaning architectural register count; register 0 always reads zero.
REQ-003 SHALL have parameter REG_ID_W, default $clog2(NUM_REGS), meaning register index width.
REQ-004 SHALL have one clock and an asynchronous active-low reset: clk  in  1  rising-edge clock.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 in_valid  in  1  fetch presents an instruction.
REQ-007 in_ready  out  1  stage accepts the instruction this cycle.
REQ-008 instruction  in  instruction_type  fetched instruction.
REQ-009 pc_in  in  XLEN  PC of the fetched instruction.
REQ-010 flush  in  1  discard the held and incoming instruction (branch or jump resolved taken).
REQ-011 write_en  in  1  writeback enable.
REQ-012 write_id  in  REG_ID_W  writeback register index.
REQ-013 write_data  in  XLEN  writeback value.
REQ-014 out_valid  out  1  the ID/EX register holds a valid instruction.
REQ-015 out_ready  in  1  execute stage consumes the ID/EX contents.
REQ-016 reg_rd_id, rs1_id, rs2_id  out  REG_ID_W each  registered destination and source indices.
REQ-017 read_data1, read_data2, immediate_data, pc_out  out  XLEN each  registered operands, immediate and PC.
REQ-018 control_signals  out  control_type  registered decoded controls.
REQ-019 hazard_stall  out  1  load-use bubble is being inserted this cycle.

Function
REQ-020 Decoding, register read and immediate extension SHALL be combinational from instruction; results SHALL be captured into the ID/EX register on the clock edge, giving 1-cycle latency.
REQ-021 The ID/EX register SHALL load when (!out_valid || out_ready); otherwise it SHALL hold all outputs unchanged.
REQ-022 Load-use hazard: hazard_stall SHALL be 1 when in_valid, out_valid, control_signals.mem_read, reg_rd_id != 0, and reg_rd_id equals the incoming rs1 or rs2 (rs2 compared only when the encoding uses rs2).
REQ-023 in_ready SHALL equal (!out_valid || out_ready) && !hazard_stall.
REQ-024 During hazard_stall with out_ready=1, the ID/EX register SHALL load a bubble: out_valid=0 and controls all zero. The instruction stays at the input and SHALL be accepted the next cycle.
REQ-025 On flush, the ID/EX register SHALL clear out_valid and controls at the next edge regardless of out_ready. The incoming instruction SHALL NOT be accepted that cycle, and in_ready SHALL be 0.
REQ-026 Register file: NUM_REGS x XLEN, written on the clock edge when write_en && write_id != 0; writes to index 0 SHALL be ignored.
REQ-027 Write-through bypass: when write_en && write_id != 0 && write_id equals a read index in the same cycle, that read SHALL return write_data.
REQ-028 Reads of index 0 SHALL return 0 even with a simultaneous write to 0.
REQ-029 When in_valid=0 and the register loads, out_valid SHALL go to 0 (no duplicate issue).
REQ-030 Simultaneous flush and hazard_stall: flush SHALL win, and the register SHALL clear.

Reset
REQ-031 When reset_n=0, out_valid SHALL be 0 and all ID/EX outputs, including controls, SHALL be 0 immediately, without waiting for a clock edge.
REQ-032 When reset_n=0, every register-file entry SHALL be 0 immediately.
REQ-033 Reset asserted mid-stall SHALL drop the stall, and hazard_stall SHALL read 0 once out_valid=0.
REQ-034 After deassertion, the first accepted instruction SHALL appear on the outputs one edge later.

Structure
REQ-035 instruction_type, control_type, the encoding enum and the immediate_extension function SHALL live in the shared common package; the new mem_read control field SHALL be added there.
REQ-036 The register file with bypass SHALL be a separate sub-module, regfile_bypass, parametrised by XLEN and NUM_REGS.
REQ-037 The control decoder SHALL be reused unchanged as an instance.

Verification
REQ-038 Reset then a single ADDI x1,x0,5 at pc 0x100 with out_ready=1: next cycle out_valid=1, immediate_data=5, reg_rd_id=1, pc_out=0x100.
REQ-039 Write x3=0xDEADBEEF while simultaneously decoding ADD x4,x3,x0: read_data1=0xDEADBEEF in the same issue.
REQ-040 LW x5 followed by ADD x6,x5,x1: exactly one cycle with hazard_stall=1, in_ready=0 and a bubble; the ADD issues on the following cycle.
REQ-041 out_ready=0 for 3 cycles with a valid instruction held: outputs stable and in_ready=0 throughout; the next instruction is accepted on the release cycle.
REQ-042 Flush asserted together with a load-use hazard: out_valid=0 next cycle and no instruction accepted; write_en to x0 with 0x1234 followed by a read of x0 returns 0.
REQ-043 reset_n pulsed low mid-stall between clock edges: out_valid and all outputs read 0 before the next rising edge.
